// File: rtl/gpio_input_conditioner.sv
// Per-pin GPIO input conditioning: pad synchronizer, consecutive-stable debounce
// with per-pin bypass, and registered single-cycle rise/fall event pulses.
module gpio_input_conditioner #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic [WIDTH-1:0] io_pins_raw,
  input  logic [WIDTH-1:0] io_bypass,
  output logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_anyEdge
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] s_p0;

  logic [CNT_W-1:0] cnt_p1  [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] pins_p1;
  logic [WIDTH-1:0] pins_nxt;
  logic [WIDTH-1:0] rise_p1;
  logic [WIDTH-1:0] fall_p1;
  logic             any_p1;

  // Stage p0: plain flop chain from the asynchronous pads, no logic in between
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      for (int n = 0; n < SYNC_STAGES; n++) sync_p0[n] <= '0;
    end else begin
      sync_p0[0] <= io_pins_raw;
      for (int n = 1; n < SYNC_STAGES; n++) sync_p0[n] <= sync_p0[n-1];
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Any cycle of agreement (or bypass) rearms the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES mismatches moves the output.
  always_comb begin
    pins_nxt = pins_p1;
    cnt_nxt  = cnt_p1;
    for (int i = 0; i < WIDTH; i++) begin
      if (io_bypass[i]) begin
        pins_nxt[i] = s_p0[i];
        cnt_nxt[i]  = '0;
      end else if (s_p0[i] == pins_p1[i]) begin
        cnt_nxt[i]  = '0;
      end else if (cnt_p1[i] == CNT_LAST) begin
        pins_nxt[i] = s_p0[i];
        cnt_nxt[i]  = '0;
      end else begin
        cnt_nxt[i]  = cnt_p1[i] + CNT_ONE;
      end
    end
  end

  // Stage p1: conditioned level and its edge events, all registered together
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
      pins_p1 <= '0;
      rise_p1 <= '0;
      fall_p1 <= '0;
      any_p1  <= 1'b0;
    end else begin
      cnt_p1  <= cnt_nxt;
      pins_p1 <= pins_nxt;
      rise_p1 <= pins_nxt & ~pins_p1;
      fall_p1 <= pins_p1 & ~pins_nxt;
      any_p1  <= |(pins_nxt ^ pins_p1);
    end
  end

  assign io_pins_read = pins_p1;
  assign io_rise      = rise_p1;
  assign io_fall      = fall_p1;
  assign io_anyEdge   = any_p1;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: two instances (debounce 16 and 4) driven with
// identical directed then random stimulus, checked against a timestamp-based model.
module tb_gpio_input_conditioner;

  localparam int W    = 32;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '1;
  logic [W-1:0] byp = '0;

  logic [W-1:0] read_a, rise_a, fall_a, read_b, rise_b, fall_b;
  logic         any_a, any_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)) dut_a (
    .io_clock(clk), .io_reset(rst), .io_pins_raw(raw), .io_bypass(byp),
    .io_pins_read(read_a), .io_rise(rise_a), .io_fall(fall_a), .io_anyEdge(any_a)
  );

  gpio_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut_b (
    .io_clock(clk), .io_reset(rst), .io_pins_raw(raw), .io_bypass(byp),
    .io_pins_read(read_b), .io_rise(rise_b), .io_fall(fall_b), .io_anyEdge(any_b)
  );

  // Model: the synchronizer is a pure delay of the sampled pad vector; a pin's
  // output takes the synchronized level once it has disagreed for D edges in a
  // row since the pin last rested (agreement, bypass, reset or a flip).
  logic [W-1:0] hist [$];
  logic [W-1:0] exp_out  [2];
  logic [W-1:0] exp_rise [2];
  logic [W-1:0] exp_fall [2];
  logic         exp_any  [2];
  int           last [2][W];
  int           dcyc [2] = '{16, 4};
  int           now = 0;

  task automatic model_edge();
    logic [W-1:0] s, prev, nxt;
    now++;
    if (rst) begin
      hist.delete();
      repeat (SYNC) hist.push_back('0);
      for (int m = 0; m < 2; m++) begin
        exp_out[m] = '0; exp_rise[m] = '0; exp_fall[m] = '0; exp_any[m] = 1'b0;
        for (int i = 0; i < W; i++) last[m][i] = now;
      end
      return;
    end
    s = hist.pop_front();
    hist.push_back(raw);
    for (int m = 0; m < 2; m++) begin
      prev = exp_out[m];
      nxt  = prev;
      for (int i = 0; i < W; i++) begin
        if (byp[i] || s[i] == prev[i] || (now - last[m][i]) == dcyc[m]) begin
          nxt[i]     = s[i];
          last[m][i] = now;
        end
      end
      exp_rise[m] = nxt & ~prev;
      exp_fall[m] = prev & ~nxt;
      exp_any[m]  = (exp_rise[m] | exp_fall[m]) != '0;
      exp_out[m]  = nxt;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, now, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("read_a", read_a, exp_out[0]);
    chk("rise_a", rise_a, exp_rise[0]);
    chk("fall_a", fall_a, exp_fall[0]);
    chk("any_a", {31'b0, any_a}, {31'b0, exp_any[0]});
    chk("read_b", read_b, exp_out[1]);
    chk("rise_b", rise_b, exp_rise[1]);
    chk("fall_b", fall_b, exp_fall[1]);
    chk("any_b", {31'b0, any_b}, {31'b0, exp_any[1]});
  endtask

  initial begin
    int n_r, n_f, rise_at;
    logic [W-1:0] tmask;

    // Pads high through reset; first released edge is edge 0
    rst = 1'b1; raw = '1; byp = '0;
    cycle(); cycle();
    chk("rst_read", read_a, '0);
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      cycle();
      chk("rel_read_low", read_a, '0);
    end
    cycle();
    chk("rel_read_high", read_a, '1);
    chk("rel_rise", rise_a, '1);
    chk("rel_any", {31'b0, any_a}, 32'd1);
    cycle();
    chk("rel_rise_once", rise_a, '0);

    // Pin 3 glitches of 15 and 16 cycles
    raw = '0;
    repeat (20) cycle();
    n_r = 0;
    for (int c = 0; c < 40; c++) begin
      raw[3] = (c < 15);
      cycle();
      if (rise_a[3]) n_r++;
    end
    chk("p3_15_norise", n_r, 0);
    chk("p3_15_low", {31'b0, read_a[3]}, 32'd0);
    n_r = 0; n_f = 0;
    for (int c = 0; c < 40; c++) begin
      raw[3] = (c < 16);
      cycle();
      if (rise_a[3]) n_r++;
      if (fall_a[3]) n_f++;
    end
    chk("p3_16_rise", n_r, 1);
    chk("p3_16_fall", n_f, 1);

    // Pin 5 bypassed, pin 6 debounced, toggled together
    byp[5] = 1'b1;
    repeat (3) cycle();
    raw[5] = 1'b1; raw[6] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c == 2) begin
        chk("byp5_high", {31'b0, read_a[5]}, 32'd1);
        chk("byp5_rise", {31'b0, rise_a[5]}, 32'd1);
        chk("p6_still_low", {31'b0, read_a[6]}, 32'd0);
      end
      if (c == 16) chk("p6_low_k16", {31'b0, read_a[6]}, 32'd0);
      if (c == 17) chk("p6_high_k17", {31'b0, read_a[6]}, 32'd1);
    end

    // Reset mid-debounce of a falling pin 0
    byp = '0; raw = '0; raw[0] = 1'b1;
    repeat (20) cycle();
    raw[0] = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst_read", read_a, '0);
    chk("mid_rst_fall", fall_a, '0);
    rst = 1'b0;
    n_f = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (fall_a[0] || fall_b[0]) n_f++;
    end
    chk("mid_rst_nofall", n_f, 0);

    // Bounce on pin 7 into the 4-cycle instance; last 0->1 captured at c=5
    n_r = 0; rise_at = -1;
    for (int c = 0; c < 16; c++) begin
      raw[7] = (c != 1 && c != 4);
      cycle();
      if (rise_b[7]) begin n_r++; rise_at = c; end
    end
    chk("bounce_rises", n_r, 1);
    chk("bounce_rise_at", rise_at, 10);

    // Pin 9: bypass pulse mid-count, then again with nothing pending
    raw[9] = 1'b1;
    repeat (10) cycle();
    byp[9] = 1'b1;
    cycle();
    chk("p9_byp_read", {31'b0, read_a[9]}, 32'd1);
    chk("p9_byp_rise", {31'b0, rise_a[9]}, 32'd1);
    byp[9] = 1'b0;
    repeat (5) cycle();
    byp[9] = 1'b1;
    cycle();
    chk("p9_byp_norise", {31'b0, rise_a[9]}, 32'd0);
    byp[9] = 1'b0;
    repeat (20) cycle();

    // Random: alternating quiet and noisy regimes, occasional bypass changes and resets
    for (int c = 0; c < 4000; c++) begin
      if ((c / 200) % 2 == 0)
        tmask = $urandom & $urandom & $urandom & $urandom & $urandom & $urandom & $urandom;
      else
        tmask = $urandom & $urandom & $urandom;
      raw = raw ^ tmask;
      if ($urandom_range(63) == 0) byp = $urandom & $urandom;
      rst = ($urandom_range(999) == 0);
      cycle();
    end
    rst = 1'b0;
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
